pe_result_serializer: RTL and testbench

- Write-side producer for the layer output register file.
- Accepts one parallel vector of R PE-array accumulator results per handshake and quantizes each to int8 (optional ReLU, rounding right shift, saturation).
- Streams the R bytes out one per cycle as a contiguous valid burst, then holds valid low for a programmable gap so the register file can drain its packed windows.
- Sits between the PE array accumulators and the output register file byte-write port.

---
 rtl/pe_result_serializer.sv | 139 +++++++++++++
 tb/tb_pe_result_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_serializer.sv
// Quantizes a vector of R signed accumulator results to int8 and streams the bytes
// as one contiguous valid burst, followed by a programmable valid-low gap.
module pe_result_serializer #(
    parameter int unsigned R  = 16,
    parameter int unsigned IW = 16,
    parameter int unsigned OW = 8
) (
    input  logic            clk_cal,
    input  logic            rst_cal,
    input  logic [R*IW-1:0] pe_res_data,
    input  logic            pe_res_vld,
    output logic            pe_res_rdy,
    input  logic            relu_en,
    input  logic [3:0]      q_shift,
    input  logic [5:0]      gap_cyc,
    input  logic            layer_clr,
    output logic [OW-1:0]   ORegfile_IData,
    output logic            ORegfile_IData_vld,
    output logic [7:0]      burst_cnt,
    output logic            busy
);

    localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(R - 1);
    localparam logic signed [IW:0] QMax = {{(IW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [IW:0] QMin = {{(IW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
    localparam logic signed [IW:0] One  = {{IW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   buf_q [R];
    logic [OW-1:0]   q_vec [R];
    logic [IdxW-1:0] idx_q, idx_d;
    logic [5:0]      gap_q, gap_d;
    logic [7:0]      bc_q, bc_d;
    logic            capture;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OW-1:0] quantize(input logic [IW-1:0] raw,
                                               input logic relu,
                                               input logic [3:0] shift);
        logic signed [IW:0] x;
        logic signed [IW:0] y;
        logic [OW-1:0]      res;
        x = {raw[IW-1], raw};
        if (relu && raw[IW-1]) begin
            x = '0;
        end
        if (shift == 4'd0) begin
            y = x;
        end else begin
            y = (x + (One <<< (shift - 4'd1))) >>> shift;
        end
        if (y > QMax) begin
            res = QMax[OW-1:0];
        end else if (y < QMin) begin
            res = QMin[OW-1:0];
        end else begin
            res = y[OW-1:0];
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(R); i++) begin
            q_vec[i] = quantize(pe_res_data[IW*i +: IW], relu_en, q_shift);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        bc_d    = bc_q;
        capture = 1'b0;
        if (layer_clr) begin
            state_d = StIdle;
            bc_d    = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pe_res_vld) begin
                        capture = 1'b1;
                        idx_d   = '0;
                        gap_d   = (gap_cyc == 6'd0) ? 6'd1 : gap_cyc;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (idx_q == IdxLast) begin
                        state_d = StGap;
                        bc_d    = bc_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_q <= 6'd1) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q - 6'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= 6'd1;
            bc_q    <= 8'd0;
            for (int i = 0; i < int'(R); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            bc_q    <= bc_d;
            if (capture) begin
                for (int i = 0; i < int'(R); i++) begin
                    buf_q[i] <= q_vec[i];
                end
            end
        end
    end

    // The index is left on the last byte sent, so the output holds it while vld is low.
    assign ORegfile_IData     = buf_q[idx_q];
    assign ORegfile_IData_vld = (state_q == StSend);
    assign pe_res_rdy         = (state_q == StIdle);
    assign busy               = (state_q != StIdle);
    assign burst_cnt          = bc_q;

endmodule

// File: tb/tb_pe_result_serializer.sv
// Randomized scoreboard bench for pe_result_serializer: a driver queues expected bytes
// with their expected cycles; a negedge monitor compares every cycle.
module tb_pe_result_serializer;

    localparam int R  = 16;
    localparam int IW = 16;
    localparam int OW = 8;

    logic            clk_cal = 1'b0;
    logic            rst_cal;
    logic [R*IW-1:0] pe_res_data;
    logic            pe_res_vld;
    logic            pe_res_rdy;
    logic            relu_en;
    logic [3:0]      q_shift;
    logic [5:0]      gap_cyc;
    logic            layer_clr;
    logic [OW-1:0]   ORegfile_IData;
    logic            ORegfile_IData_vld;
    logic [7:0]      burst_cnt;
    logic            busy;

    pe_result_serializer #(.R(R), .IW(IW), .OW(OW)) dut (
        .clk_cal            (clk_cal),
        .rst_cal            (rst_cal),
        .pe_res_data        (pe_res_data),
        .pe_res_vld         (pe_res_vld),
        .pe_res_rdy         (pe_res_rdy),
        .relu_en            (relu_en),
        .q_shift            (q_shift),
        .gap_cyc            (gap_cyc),
        .layer_clr          (layer_clr),
        .ORegfile_IData     (ORegfile_IData),
        .ORegfile_IData_vld (ORegfile_IData_vld),
        .burst_cnt          (burst_cnt),
        .busy               (busy)
    );

    always #5 clk_cal = ~clk_cal;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         vec[R];
    int         exp_bc = 0;
    int         last_cap = 0;
    int         last_g = 1;
    bit         chk_en = 1'b0;
    logic [7:0] last_byte = 8'd0;

    always @(posedge clk_cal) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference quantizer: plain integer arithmetic.
    function automatic logic [7:0] qref(input int x, input bit relu, input int sh);
        int y;
        if (relu && x < 0) x = 0;
        if (sh == 0) y = x;
        else y = (x + (1 << (sh - 1))) >>> sh;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return 8'(y);
    endfunction

    // Monitor: every cycle, vld must match the scoreboard timeline.
    always @(negedge clk_cal) begin
        if (chk_en) begin
            bit exp_v;
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("vld", {31'd0, ORegfile_IData_vld}, {31'd0, exp_v});
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (exp_v) chk("byte", {24'd0, ORegfile_IData}, {24'd0, e.b});
                last_byte = e.b;
            end else if (!ORegfile_IData_vld) begin
                chk("hold_byte", {24'd0, ORegfile_IData}, {24'd0, last_byte});
            end
        end
        if (rst_cal) last_byte = 8'd0;
    end

    task automatic flush_future();
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    endtask

    task automatic rand_vec();
        logic signed [15:0] t;
        for (int i = 0; i < R; i++) begin
            t = 16'($urandom);
            vec[i] = t;
        end
    endtask

    // Present vec until accepted; returns the capture edge index.
    task automatic issue(input bit relu, input int sh, input int gap, input bit chk_next,
                         output int e);
        int waited = 0;
        for (int i = 0; i < R; i++) pe_res_data[IW*i +: IW] = 16'(vec[i]);
        relu_en    = relu;
        q_shift    = 4'(sh);
        gap_cyc    = 6'(gap);
        pe_res_vld = 1'b1;
        while (!pe_res_rdy && waited < 300) begin
            @(posedge clk_cal); #1;
            waited++;
        end
        if (!pe_res_rdy) begin
            chk("accept_timeout", 32'd0, 32'd1);
            pe_res_vld = 1'b0;
            e = cyc;
            return;
        end
        e = cyc + 1;
        if (chk_next) chk("next_capture_cycle", e, last_cap + R + last_g + 1);
        for (int k = 0; k < R; k++) sb.push_back('{e + k, qref(vec[k], relu, sh)});
        exp_bc++;
        last_cap = e;
        last_g   = (gap == 0) ? 1 : gap;
        @(posedge clk_cal); #1;
    endtask

    task automatic wait_idle(input int e);
        int exp_idle = e + R + last_g;
        int waited = 0;
        while (waited < 300) begin
            chk("busy", {31'd0, busy}, {31'd0, (cyc < exp_idle)});
            if (pe_res_rdy) break;
            @(posedge clk_cal); #1;
            waited++;
        end
        chk("idle_cycle", cyc, exp_idle);
        chk("burst_cnt", {24'd0, burst_cnt}, exp_bc % 256);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {31'd0, pe_res_rdy}, 32'd1);
        chk({tag, "_vld"}, {31'd0, ORegfile_IData_vld}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_burst_cnt"}, {24'd0, burst_cnt}, 32'd0);
    endtask

    initial begin
        int e;
        int c0;
        rst_cal = 1'b1; pe_res_vld = 1'b0; layer_clr = 1'b0; pe_res_data = '0;
        relu_en = 1'b0; q_shift = 4'd0; gap_cyc = 6'd0;
        repeat (3) begin @(posedge clk_cal); #1; end
        rst_cal = 1'b0;
        chk_en  = 1'b1;
        check_reset_outputs("reset");
        chk("reset_data", {24'd0, ORegfile_IData}, 32'd0);

        // Ramp i*64 with shift 6 gives bytes 0..15.
        for (int i = 0; i < R; i++) vec[i] = i * 64;
        issue(1'b0, 6, 3, 1'b0, e); pe_res_vld = 1'b0; wait_idle(e);

        // Saturation and ReLU corners.
        for (int i = 0; i < R; i++) vec[i] = 0;
        vec[0] = -300; vec[1] = 300; vec[2] = -1; vec[3] = 129; vec[4] = 32767; vec[5] = -32768;
        issue(1'b0, 0, 2, 1'b0, e); pe_res_vld = 1'b0; wait_idle(e);
        issue(1'b1, 0, 1, 1'b0, e); pe_res_vld = 1'b0; wait_idle(e);

        // Round-half-up at shift 2.
        rand_vec();
        vec[0] = 5; vec[1] = 6; vec[2] = -6; vec[3] = -5;
        issue(1'b0, 2, 4, 1'b0, e); pe_res_vld = 1'b0; wait_idle(e);

        // Clear in idle, then back-to-back vectors with gap 0.
        layer_clr = 1'b1; @(posedge clk_cal); #1; layer_clr = 1'b0;
        exp_bc = 0;
        chk("clr_idle_burst_cnt", {24'd0, burst_cnt}, 32'd0);
        for (int v = 0; v < 4; v++) begin
            rand_vec();
            issue(1'($urandom), int'($urandom_range(0, 15)), 0, v > 0, e);
        end
        pe_res_vld = 1'b0;
        wait_idle(e);

        // Clear while byte 5 is on the output.
        rand_vec();
        issue(1'b0, 3, 5, 1'b0, e); pe_res_vld = 1'b0;
        repeat (5) begin @(posedge clk_cal); #1; end
        layer_clr = 1'b1;
        flush_future();
        exp_bc = 0;
        @(posedge clk_cal); #1;
        layer_clr = 1'b0;
        check_reset_outputs("clr_burst");
        rand_vec();
        issue(1'b1, 4, 2, 1'b0, e); pe_res_vld = 1'b0; wait_idle(e);

        // Random vectors, settings and idle spacing.
        for (int v = 0; v < 6; v++) begin
            rand_vec();
            issue(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'b0, e);
            pe_res_vld = 1'b0;
            wait_idle(e);
            repeat ($urandom_range(0, 3)) begin @(posedge clk_cal); #1; end
        end

        // Reset pulse during a long gap, with the next vector already presented.
        rand_vec();
        issue(1'b0, 5, 40, 1'b0, e); pe_res_vld = 1'b0;
        repeat (R + 5) begin @(posedge clk_cal); #1; end
        rand_vec();
        for (int i = 0; i < R; i++) pe_res_data[IW*i +: IW] = 16'(vec[i]);
        rst_cal    = 1'b1;
        pe_res_vld = 1'b1;
        flush_future();
        exp_bc = 0;
        @(posedge clk_cal); #1;
        rst_cal = 1'b0;
        check_reset_outputs("mid_gap_reset");
        chk("mid_gap_reset_data", {24'd0, ORegfile_IData}, 32'd0);
        c0 = cyc;
        issue(1'b0, 1, 2, 1'b0, e); pe_res_vld = 1'b0;
        chk("accept_after_reset", e, c0 + 1);
        wait_idle(e);

        repeat (3) begin @(posedge clk_cal); #1; end
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
